// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-RAM load controller: FSM state
// encodings, counter widths and the RAM depth derivation.
package imem_load_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN0  = 3'd1,
      ST_LEN1  = 3'd2,
      ST_DATA  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_e;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned GAP_W = 16;

   // Word capacity of a byte-addressed RAM holding 32-bit words.
   function automatic int unsigned max_words(input int unsigned addr_w);
      return 32'd1 << (addr_w - 32'd2);
   endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader byte stream, core fetch address and instruction-RAM port, bundled
// so the controller sees them as one bus.
interface imem_load_ctrl_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [31:0]       mem_wdata;

   modport master (
      input  rx_valid,
      input  rx_data,
      input  fetch_addr,
      output rx_ready,
      output mem_addr,
      output mem_we,
      output mem_wdata
   );

   modport slave (
      output rx_valid,
      output rx_data,
      output fetch_addr,
      input  rx_ready,
      input  mem_addr,
      input  mem_we,
      input  mem_wdata
   );
endinterface

// File: rtl/imem_word_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_done flags the
// byte that completes a word, in the same cycle it is presented.
module imem_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_done
);

   logic [31:0] word_q, word_d;
   logic [1:0]  byte_idx_q, byte_idx_d;

   // Shift new bytes in from the top so the first byte lands in [7:0] after four.
   always_comb begin
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      if (clear) begin
         word_d     = 32'd0;
         byte_idx_d = 2'd0;
      end else if (byte_valid) begin
         word_d     = {byte_data, word_q[31:8]};
         byte_idx_d = byte_idx_q + 2'd1;
      end else begin
         word_d     = word_q;
         byte_idx_d = byte_idx_q;
      end
   end

   // Packer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q     <= 32'd0;
         byte_idx_q <= 2'd0;
      end else begin
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
      end
   end

   assign word      = word_q;
   assign word_done = byte_valid && (byte_idx_q == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-RAM write controller: passes core fetches through when idle and
// otherwise streams a length-prefixed program image into the RAM from word 0.
module imem_load_ctrl
   import imem_load_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_start,
   imem_load_ctrl_if.master       bus,
   output logic                   cpu_hold,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned      WIDX_W      = ADDR_W - 2;
   localparam int unsigned      MAX_WORDS   = max_words(ADDR_W);
   localparam logic [CNT_W-1:0] MAX_WORDS_C = CNT_W'(MAX_WORDS);
   localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(TIMEOUT_CYC - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WIDX_W-1:0]   widx_q, widx_d;
   logic [GAP_W-1:0]    gap_q, gap_d;

   logic                rx_ready_s;
   logic                rx_fire_s;
   logic                pk_clear_s;
   logic                pk_valid_s;
   logic                pk_word_done_s;
   logic [31:0]         pk_word_s;
   logic [CNT_W-1:0]    len_new_s;

   assign rx_ready_s = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA);
   assign rx_fire_s  = rx_ready_s && bus.rx_valid;
   assign pk_valid_s = rx_fire_s && (state_q == ST_DATA);
   assign len_new_s  = {bus.rx_data, cnt_q[7:0]};

   imem_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (pk_clear_s),
      .byte_valid (pk_valid_s),
      .byte_data  (bus.rx_data),
      .word       (pk_word_s),
      .word_done  (pk_word_done_s)
   );

   // Next-state logic. The gap counter defaults to zero and only advances on a
   // stalled cycle in a receiving state, so any accepted byte or state change clears it.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      widx_d     = widx_q;
      gap_d      = 16'd0;
      pk_clear_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               state_d = ST_LEN0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LEN0: begin
            if (rx_fire_s) begin
               cnt_d   = {8'h00, bus.rx_data};
               state_d = ST_LEN1;
            end else if (gap_q == GAP_LAST) begin
               state_d = ST_ERR;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         ST_LEN1: begin
            if (rx_fire_s) begin
               cnt_d = len_new_s;
               if (len_new_s == 16'd0) begin
                  state_d = ST_DONE;
               end else if (len_new_s > MAX_WORDS_C) begin
                  state_d = ST_ERR;
               end else begin
                  state_d    = ST_DATA;
                  widx_d     = '0;
                  pk_clear_s = 1'b1;
               end
            end else if (gap_q == GAP_LAST) begin
               state_d = ST_ERR;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         ST_DATA: begin
            if (rx_fire_s) begin
               if (pk_word_done_s) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_DATA;
               end
            end else if (gap_q == GAP_LAST) begin
               state_d = ST_ERR;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         ST_WRITE: begin
            widx_d = widx_q + WIDX_W'(1);
            if (CNT_W'(widx_q) == (cnt_q - 16'd1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            if (load_start) begin
               state_d = ST_LEN0;
            end else begin
               state_d = ST_ERR;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'd0;
         widx_q  <= '0;
         gap_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         widx_q  <= widx_d;
         gap_q   <= gap_d;
      end
   end

   // Outputs decode from registered state only; fetch owns the RAM port in IDLE.
   assign bus.rx_ready  = rx_ready_s;
   assign bus.mem_we    = (state_q == ST_WRITE);
   assign bus.mem_wdata = pk_word_s;
   assign bus.mem_addr  = (state_q == ST_IDLE) ? bus.fetch_addr : {widx_q, 2'b00};
   assign cpu_hold      = (state_q != ST_IDLE);
   assign busy          = (state_q != ST_IDLE) && (state_q != ST_ERR);
   assign done          = (state_q == ST_DONE);
   assign err           = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: expected RAM writes are queued as the
// image is driven and retired by a write monitor.
`timescale 1ns/1ps
module tb_imem_load_ctrl;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic load_start;
   logic cpu_hold, busy, done, err;

   imem_load_ctrl_if #(.ADDR_W(ADDR_W)) bus();

   imem_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .bus        (bus.master),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   fail_cnt = 0;
   int   we_cnt = 0;
   int   done_cnt = 0;
   wr_t  sb[$];
   wr_t  mon_e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      check(tag, {31'd0, obs}, {31'd0, exp});
   endtask

   task automatic push_word(input int idx, input logic [31:0] data);
      wr_t w;
      w.addr = 8'(idx * 4);
      w.data = data;
      sb.push_back(w);
   endtask

   // Called at a negedge; returns at the negedge after the byte is taken.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (!bus.rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_b("rx_ready_wait", 1'b0, 1'b1);
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   // Write monitor: every mem_we must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         we_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_write", {24'd0, bus.mem_addr}, 32'hFFFF_FFFF);
         end else begin
            mon_e = sb.pop_front();
            check("wr_addr", {24'd0, bus.mem_addr}, {24'd0, mon_e.addr});
            check("wr_data", bus.mem_wdata, mon_e.data);
         end
      end
      if (done === 1'b1) done_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] img[10];
      logic [7:0] str[258];
      logic [31:0] w;
      int we0, d0, idx, cyc, rdy_low, rdy_bad;
      logic acc;

      img = '{8'h02, 8'h00, 8'hb7, 8'h20, 8'h00, 8'h00, 8'h93, 8'h80, 8'hf0, 8'h70};
      rst = 1'b1;
      load_start = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      bus.fetch_addr = 8'h5c;
      repeat (3) @(negedge clk);

      // Reset state
      check_b("rst_cpu_hold", cpu_hold, 1'b0);
      check_b("rst_busy", busy, 1'b0);
      check_b("rst_done", done, 1'b0);
      check_b("rst_err", err, 1'b0);
      check_b("rst_mem_we", bus.mem_we, 1'b0);
      check_b("rst_rx_ready", bus.rx_ready, 1'b0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Fetch pass-through in IDLE
      for (int i = 0; i < 4; i++) begin
         bus.fetch_addr = 8'(i * 36 + 16);
         #1;
         check("idle_fetch_addr", {24'd0, bus.mem_addr}, 32'(i * 36 + 16));
         @(negedge clk);
      end

      // Normal two-word load
      bus.fetch_addr = 8'h80;
      we0 = we_cnt;
      d0 = done_cnt;
      start_load();
      check_b("load_cpu_hold", cpu_hold, 1'b1);
      check_b("load_busy", busy, 1'b1);
      check_b("load_rx_ready", bus.rx_ready, 1'b1);
      check("load_fetch_ignored", {24'd0, bus.mem_addr}, 32'd0);
      push_word(0, 32'h000020b7);
      push_word(1, 32'h70f08093);
      for (int i = 0; i < 10; i++) send_byte(img[i]);
      check_b("normal_write_cycle", bus.mem_we, 1'b1);
      check_b("normal_write_rdy", bus.rx_ready, 1'b0);
      @(negedge clk);
      check_b("normal_done", done, 1'b1);
      check_b("normal_done_hold", cpu_hold, 1'b1);
      @(negedge clk);
      check_b("normal_done_clear", done, 1'b0);
      check_b("normal_hold_rel", cpu_hold, 1'b0);
      check_b("normal_busy_rel", busy, 1'b0);
      check("normal_we_count", 32'(we_cnt - we0), 32'd2);
      check("normal_done_count", 32'(done_cnt - d0), 32'd1);

      // Zero length
      we0 = we_cnt;
      start_load();
      send_byte(8'h00);
      send_byte(8'h00);
      check_b("zero_done", done, 1'b1);
      check_b("zero_err", err, 1'b0);
      check_b("zero_we", bus.mem_we, 1'b0);
      @(negedge clk);
      check_b("zero_hold_rel", cpu_hold, 1'b0);
      check("zero_we_count", 32'(we_cnt - we0), 32'd0);

      // Oversize length, then recovery with load_start ignored while busy
      start_load();
      send_byte(8'h41);
      send_byte(8'h00);
      check_b("over_err", err, 1'b1);
      check_b("over_hold", cpu_hold, 1'b1);
      check_b("over_busy", busy, 1'b0);
      check_b("over_rx_ready", bus.rx_ready, 1'b0);
      bus.rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.rx_valid = 1'b0;
      check_b("over_err_sticky", err, 1'b1);
      check("over_we_count", 32'(we_cnt - we0), 32'd0);
      start_load();
      check_b("over_err_clear", err, 1'b0);
      check_b("over_relen0", bus.rx_ready, 1'b1);
      send_byte(8'h00);
      start_load();
      send_byte(8'h00);
      check_b("busy_start_ignored", done, 1'b1);
      @(negedge clk);

      // Timeout: 16 stalled cycles abort
      start_load();
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'hb7);
      repeat (15) @(negedge clk);
      check_b("to_before_err", err, 1'b0);
      @(negedge clk);
      check_b("to_err", err, 1'b1);
      check_b("to_hold", cpu_hold, 1'b1);

      // Timeout: byte on the final allowed cycle wins
      we0 = we_cnt;
      start_load();
      push_word(0, 32'h000020b7);
      push_word(1, 32'h70f08093);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'hb7);
      repeat (15) @(negedge clk);
      check_b("to_edge_no_err", err, 1'b0);
      send_byte(8'h20);
      check_b("to_edge_accepted", err, 1'b0);
      check_b("to_edge_still_data", bus.rx_ready, 1'b1);
      for (int i = 4; i < 10; i++) send_byte(img[i]);
      @(negedge clk);
      check_b("to_edge_done", done, 1'b1);
      @(negedge clk);
      check("to_edge_we_count", 32'(we_cnt - we0), 32'd2);

      // Streaming 64 words with rx_valid held high
      we0 = we_cnt;
      str[0] = 8'h40;
      str[1] = 8'h00;
      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         push_word(i, w);
         for (int b = 0; b < 4; b++) str[2 + i * 4 + b] = w[b*8 +: 8];
      end
      start_load();
      idx = 0;
      cyc = 0;
      rdy_low = 0;
      rdy_bad = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data = str[0];
      while (idx < 258 && cyc < 2000) begin
         acc = bus.rx_ready;
         if (!acc) begin
            rdy_low++;
            if (bus.mem_we !== 1'b1) rdy_bad++;
         end
         @(negedge clk);
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 258) bus.rx_data = str[idx];
         end
      end
      bus.rx_valid = 1'b0;
      check("stream_bytes", 32'(idx), 32'd258);
      check("stream_cycles", 32'(cyc), 32'd321);
      check("stream_rdy_low", 32'(rdy_low), 32'd63);
      check("stream_rdy_low_not_write", 32'(rdy_bad), 32'd0);
      check_b("stream_last_write", bus.mem_we, 1'b1);
      check("stream_last_addr", {24'd0, bus.mem_addr}, 32'h0000_00fc);
      @(negedge clk);
      check_b("stream_done", done, 1'b1);
      @(negedge clk);
      check("stream_we_count", 32'(we_cnt - we0), 32'd64);

      // Reset in the middle of DATA
      we0 = we_cnt;
      start_load();
      push_word(0, 32'h000020b7);
      for (int i = 0; i < 7; i++) send_byte(img[i]);
      rst = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'h80;
      @(negedge clk);
      rst = 1'b0;
      check_b("mid_rst_hold", cpu_hold, 1'b0);
      check_b("mid_rst_busy", busy, 1'b0);
      check_b("mid_rst_we", bus.mem_we, 1'b0);
      check_b("mid_rst_rdy", bus.rx_ready, 1'b0);
      repeat (5) @(negedge clk);
      bus.rx_valid = 1'b0;
      check_b("idle_rx_not_ready", bus.rx_ready, 1'b0);
      check("mid_rst_we_count", 32'(we_cnt - we0), 32'd1);
      bus.fetch_addr = 8'h3c;
      #1;
      check("post_rst_fetch", {24'd0, bus.mem_addr}, 32'h0000_003c);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
